// File: rtl/prefetch_mem_arbiter.sv
// prefetch_mem_arbiter: shares one memory read port between cache demand misses
// and queued next-line prefetches; demand wins, one read outstanding at a time.
// Ports: clk, rst_n (async, active-low); demand_req/addr -> demand_ready/block;
// pf_req/addr -> pf_full, pf_drop, pf_valid, pf_ret_addr, pf_block;
// mem_req/addr -> memory, mem_valid/block <- memory.
// Optional: define PF_DEDUP_EN to drop duplicate prefetches and let a demand
// cancel a queued prefetch of the same block.
module prefetch_mem_arbiter #(
  parameter int block_size_byte = 16,
  parameter int pf_depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         demand_req,
  input  logic [31:0]                  demand_addr,
  output logic                         demand_ready,
  output logic [block_size_byte*8-1:0] demand_block,
  input  logic                         pf_req,
  input  logic [31:0]                  pf_addr,
  output logic                         pf_full,
  output logic                         pf_drop,
  output logic                         pf_valid,
  output logic [31:0]                  pf_ret_addr,
  output logic [block_size_byte*8-1:0] pf_block,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_valid,
  input  logic [block_size_byte*8-1:0] mem_block
);

  localparam int PW = $clog2(pf_depth);
  localparam int CW = PW + 1;
  localparam logic [31:0] MASK =
    ~(32'(block_size_byte) - 32'd1);
  localparam logic [CW-1:0] FULLC = CW'(pf_depth);

  typedef enum logic [1:0] {
    IDLE,
    DEM_WAIT,
    PF_WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [31:0]   q_addr [pf_depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          full, empty, head_live;
  logic          push, pop, pf_dup;
  logic          grant_dem, grant_pf, done;
  logic [31:0]   dem_al, pf_al;

  assign dem_al = demand_addr & MASK;
  assign pf_al  = pf_addr & MASK;
  assign full   = (count == FULLC);
  assign empty  = (count == '0);
  assign push   = pf_req && !full && !pf_dup;

`ifdef PF_DEDUP_EN
  logic [pf_depth-1:0] q_live;

  assign head_live = q_live[rd_ptr];

  always_comb begin
    pf_dup = (state == PF_WAIT) && (mem_addr == pf_al);
    for (int i = 0; i < pf_depth; i++)
      if (q_live[i] && (q_addr[i] == pf_al))
        pf_dup = 1'b1;
  end

  // A granted demand kills queued copies; the
  // dead slot is popped without a memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_live <= '0;
    end else begin
      if (grant_dem)
        for (int i = 0; i < pf_depth; i++)
          if (q_addr[i] == dem_al)
            q_live[i] <= 1'b0;
      if (pop)
        q_live[rd_ptr] <= 1'b0;
      if (push)
        q_live[wr_ptr] <= 1'b1;
    end
  end
`else
  assign head_live = 1'b1;
  assign pf_dup    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant_dem = 1'b0;
    grant_pf  = 1'b0;
    pop       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (demand_req) begin
          grant_dem = 1'b1;
          state_nx  = DEM_WAIT;
        end else if (!empty) begin
          pop = 1'b1;
          if (head_live) begin
            grant_pf = 1'b1;
            state_nx = PF_WAIT;
          end
        end
      end
      DEM_WAIT, PF_WAIT: begin
        if (mem_valid) begin
          done     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + 1'b1;
    else if (!push && pop)
      count_nx = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      q_addr[wr_ptr] <= pf_al;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pf_full <= 1'b0;
      pf_drop <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nx;
      pf_full <= (count_nx == FULLC);
      pf_drop <= pf_req && !push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      demand_ready <= 1'b0;
      demand_block <= '0;
      pf_valid     <= 1'b0;
      pf_block     <= '0;
      pf_ret_addr  <= '0;
    end else begin
      demand_ready <= 1'b0;
      pf_valid     <= 1'b0;
      if (grant_dem) begin
        mem_req  <= 1'b1;
        mem_addr <= dem_al;
      end else if (grant_pf) begin
        mem_req  <= 1'b1;
        mem_addr <= q_addr[rd_ptr];
      end
      if (done) begin
        mem_req <= 1'b0;
        if (state == DEM_WAIT) begin
          demand_ready <= 1'b1;
          demand_block <= mem_block;
        end else begin
          pf_valid    <= 1'b1;
          pf_block    <= mem_block;
          pf_ret_addr <= mem_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefetch_mem_arbiter.sv
// tb_prefetch_mem_arbiter: directed and random stimulus, queue-based model,
// per-cycle expected outputs pushed to a scoreboard and checked by a monitor.
module tb_prefetch_mem_arbiter;

  localparam int BW = 128;
  localparam int DEPTH = 4;
  localparam logic [31:0] MASK = 32'hFFFF_FFF0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          demand_req = 1'b0;
  logic [31:0]   demand_addr = '0;
  logic          demand_ready;
  logic [BW-1:0] demand_block;
  logic          pf_req = 1'b0;
  logic [31:0]   pf_addr = '0;
  logic          pf_full, pf_drop, pf_valid;
  logic [31:0]   pf_ret_addr;
  logic [BW-1:0] pf_block;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_valid = 1'b0;
  logic [BW-1:0] mem_block = '0;

  prefetch_mem_arbiter #(
    .block_size_byte(16),
    .pf_depth(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .demand_req(demand_req),
    .demand_addr(demand_addr),
    .demand_ready(demand_ready),
    .demand_block(demand_block),
    .pf_req(pf_req), .pf_addr(pf_addr),
    .pf_full(pf_full), .pf_drop(pf_drop),
    .pf_valid(pf_valid),
    .pf_ret_addr(pf_ret_addr),
    .pf_block(pf_block),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_block(mem_block)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mreq;
    logic [31:0] maddr;
    bit          dr;
    logic [BW-1:0] dblk;
    bit          pv;
    logic [31:0] raddr;
    logic [BW-1:0] pblk;
    bit          drop;
    bit          full;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of pending prefetches plus who owns the port.
  logic [31:0]   qa[$];
  bit            ql[$];
  int            m_busy;   // 0 free, 1 demand read, 2 prefetch read
  bit            m_resp;
  logic [31:0]   m_cur;
  bit            m_dr, m_pv, m_drop;
  logic [BW-1:0] m_dblk, m_pblk;
  logic [31:0]   m_raddr;

  function automatic logic [BW-1:0] blk_of(input logic [31:0] a);
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++)
      b[i*32 +: 32] = a ^ (32'h9E37_0000 + 32'(i));
    return b;
  endfunction

  task automatic model_reset();
    qa.delete();
    ql.delete();
    m_busy = 0; m_resp = 0; m_cur = '0;
    m_dr = 0; m_pv = 0; m_drop = 0;
    m_dblk = '0; m_pblk = '0; m_raddr = '0;
  endtask

  task automatic model_edge(input bit dq, input logic [31:0] da,
                            input bit pq, input logic [31:0] pa,
                            input bit mv, input logic [BW-1:0] mb);
    logic [31:0] dal, pal, h;
    bit full, dup, live;
    dal = da & MASK;
    pal = pa & MASK;
    full = (qa.size() == DEPTH);
    dup = 0;
`ifdef PF_DEDUP_EN
    foreach (qa[i]) if (ql[i] && qa[i] == pal) dup = 1;
    if (m_busy == 2 && m_cur == pal) dup = 1;
`endif
    m_drop = pq && (full || dup);
    m_dr = 0;
    m_pv = 0;
    if (m_resp) begin
      m_resp = 0;
    end else if (m_busy != 0) begin
      if (mv) begin
        if (m_busy == 1) begin
          m_dr = 1; m_dblk = mb;
        end else begin
          m_pv = 1; m_pblk = mb; m_raddr = m_cur;
        end
        m_busy = 0;
        m_resp = 1;
      end
    end else if (dq) begin
      m_busy = 1;
      m_cur = dal;
`ifdef PF_DEDUP_EN
      foreach (qa[i]) if (qa[i] == dal) ql[i] = 0;
`endif
    end else if (qa.size() != 0) begin
      h = qa.pop_front();
      live = ql.pop_front();
      if (live) begin
        m_busy = 2;
        m_cur = h;
      end
    end
    if (pq && !m_drop) begin
      qa.push_back(pal);
      ql.push_back(1'b1);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.mreq = (m_busy != 0);
    e.maddr = m_cur;
    e.dr = m_dr; e.dblk = m_dblk;
    e.pv = m_pv; e.raddr = m_raddr; e.pblk = m_pblk;
    e.drop = m_drop;
    e.full = (qa.size() == DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [BW-1:0] act,
                     input logic [BW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  task automatic step(input bit dq, input logic [31:0] da,
                      input bit pq, input logic [31:0] pa,
                      input bit mv, input logic [BW-1:0] mb);
    @(negedge clk);
    rst_n = 1'b1;
    demand_req = dq; demand_addr = da;
    pf_req = pq; pf_addr = pa;
    mem_valid = mv; mem_block = mb;
    model_edge(dq, da, pq, pa, mv, mb);
    push_exp();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      demand_req = 1'b0; pf_req = 1'b0;
      mem_valid = (k == 1);
      mem_block = {BW/32{32'hDEAD_BEEF}};
      model_reset();
      push_exp();
    end
  endtask

  task automatic auto_cycles(input int n, input bit dq0,
                             input logic [31:0] da);
    bit dq;
    dq = dq0;
    for (int k = 0; k < n; k++) begin
      step(dq, da, 1'b0, 32'h0, m_busy != 0, blk_of(m_cur));
      if (m_dr) dq = 0;
    end
  endtask

  // Monitor: one expectation per cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_req", mem_req, e.mreq);
        chk("mem_addr", mem_addr, e.maddr);
        chk("demand_ready", demand_ready, e.dr);
        chk("demand_block", demand_block, e.dblk);
        chk("pf_valid", pf_valid, e.pv);
        chk("pf_ret_addr", pf_ret_addr, e.raddr);
        chk("pf_block", pf_block, e.pblk);
        chk("pf_drop", pf_drop, e.drop);
        chk("pf_full", pf_full, e.full);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit dem_on, pq, mv;
    logic [31:0] dem_a, pa;
    logic [BW-1:0] mb;
    int wcnt, lat;
    model_reset();
    do_reset();

    // single demand, 5-cycle memory latency
    for (int k = 0; k < 5; k++)
      step(1, 32'h0000_1234, 0, 0, 0, '0);
    step(1, 32'h0000_1234, 0, 0, 1, {BW/8{8'hAA}});
    auto_cycles(3, 0, 0);

    // prefetch only
    step(0, 0, 1, 32'h40, 0, '0);
    step(0, 0, 1, 32'h5C, 0, '0);
    auto_cycles(10, 0, 0);

    // demand beats queued prefetch
    step(0, 0, 1, 32'h100, 0, '0);
    auto_cycles(10, 1, 32'h200);

    // demand raised during a prefetch read
    step(0, 0, 1, 32'h100, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    step(1, 32'h208, 0, 0, 0, '0);
    auto_cycles(10, 1, 32'h208);

    // overflow with memory stalled, then push during pop while full
    for (int k = 0; k < 6; k++)
      step(0, 0, 1, 32'h800 + 32'(k * 16), 0, '0);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, blk_of(m_cur));
    step(0, 0, 1, 32'h900, 0, '0);
    step(0, 0, 1, 32'h910, 0, '0);
    auto_cycles(30, 0, 0);

    // duplicate prefetch; demand hitting a queued prefetch
    step(0, 0, 1, 32'h300, 0, '0);
    step(0, 0, 1, 32'h304, 0, '0);
    auto_cycles(6, 0, 0);
    step(0, 0, 1, 32'h400, 0, '0);
    step(0, 0, 1, 32'h300, 0, '0);
    step(1, 32'h300, 0, 0, 1, blk_of(m_cur));
    auto_cycles(12, 1, 32'h300);

    // reset during a demand read with two queued prefetches
    step(1, 32'h600, 1, 32'h500, 0, '0);
    step(1, 32'h600, 1, 32'h510, 0, '0);
    do_reset();
    step(0, 0, 0, 0, 1, {BW/32{32'h1234_5678}});
    auto_cycles(4, 0, 0);

    // random traffic
    dem_on = 0; dem_a = '0; wcnt = 0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        do_reset();
        dem_on = 0;
        continue;
      end
      if (m_busy == 0) begin
        wcnt = 0;
        lat = $urandom_range(0, 5);
      end
      if (!dem_on && $urandom_range(0, 7) == 0) begin
        dem_on = 1;
        dem_a = 32'h1000 + 32'($urandom_range(0, 255));
      end
      pq = ($urandom_range(0, 2) == 0);
      pa = 32'h1000 + 32'($urandom_range(0, 255));
      if (m_busy != 0) begin
        mv = (wcnt >= lat);
        wcnt++;
        mb = blk_of(m_cur);
      end else begin
        mv = ($urandom_range(0, 9) == 0);
        mb = {BW/32{32'($urandom())}};
      end
      step(dem_on, dem_a, pq, pa, mv, mb);
      if (m_dr) dem_on = 0;
    end
    auto_cycles(40, 0, 0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", BW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
